jtgng_rom_arb: RTL and testbench



---
 rtl/jtgng_rom_pkg.sv | 13 +
 rtl/jtgng_rom_dly.sv | 27 ++
 rtl/jtgng_rom_arb.sv | 150 +++++++++++++++
 tb/tb_jtgng_rom_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtgng_rom_pkg.sv
// Shared definitions for the SDRAM ROM-slot arbiter: default address width,
// latency bound and slot index width helper.
package jtgng_rom_pkg;

    localparam int ROM_AW      = 22;
    localparam int LATENCY_MAX = 4;

    // Width needed to hold a slot index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtgng_rom_dly.sv
// Cen-gated shift line used to align the issued one-hot with SDRAM read
// latency. Synchronous clear empties every stage.
module jtgng_rom_dly #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (cen) begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/jtgng_rom_arb.sv
// Parametrised SDRAM ROM-slot arbiter. Define JTGNG_ROM_RR_EN to serve slots
// at or above FIXED_PRI round-robin; otherwise strict fixed priority.
module jtgng_rom_arb
    import jtgng_rom_pkg::*;
#(
    parameter int                  SLOTS     = 8,
    parameter int                  AW        = ROM_AW,
    parameter logic [SLOTS*AW-1:0] OFFSETS   = '0,
    parameter int                  LATENCY   = 1,
    parameter int                  READY_DLY = 4,
    parameter int                  FIXED_PRI = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [AW-1:0]       sdram_addr,
    output logic                sdram_re,
    output logic [SLOTS-1:0]    slot_we,
    output logic [3:0]          grant_idx,
    output logic                ready
);

    localparam int IW = idx_w(SLOTS);
    localparam int CW = $clog2(READY_DLY + 2);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("jtgng_rom_arb: LATENCY out of range");
    end

    logic                clr;
    logic [AW-1:0]       abs_addr [SLOTS];
    logic [SLOTS-1:0]    inflight_reg;
    logic [SLOTS-1:0]    eligible;
    logic [SLOTS-1:0]    issue_vec;
    logic [SLOTS-1:0]    we_next;
    logic [IW:0]         pick_res;
    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;

    assign clr = rst | loop_rst | downloading;

    // Absolute address per slot; AW-bit sum wraps naturally.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_abs
        assign abs_addr[gi] = OFFSETS[gi*AW +: AW] + slot_addr[gi*AW +: AW];
    end

`ifdef JTGNG_ROM_RR_EN
    logic [IW-1:0] rr_ptr_reg;

    function automatic logic [IW:0] pick(input logic [SLOTS-1:0] elig,
                                         input logic [IW-1:0]    ptr);
        logic          found;
        logic [IW-1:0] w;
        int            idx;
        found = 1'b0;
        w     = '0;
        for (int i = 0; i < FIXED_PRI; i++) begin
            if (!found && elig[IW'(i)]) begin
                found = 1'b1;
                w     = IW'(i);
            end
        end
        // Scan the shared region starting at the pointer, wrapping within it.
        for (int j = 0; j < SLOTS - FIXED_PRI; j++) begin
            idx = int'(ptr) + j;
            if (idx >= SLOTS) idx = idx - (SLOTS - FIXED_PRI);
            if (!found && elig[IW'(idx)]) begin
                found = 1'b1;
                w     = IW'(idx);
            end
        end
        return {found, w};
    endfunction

    assign pick_res = pick(eligible, rr_ptr_reg);
`else
    function automatic logic [IW:0] pick(input logic [SLOTS-1:0] elig);
        logic          found;
        logic [IW-1:0] w;
        found = 1'b0;
        w     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && elig[IW'(i)]) begin
                found = 1'b1;
                w     = IW'(i);
            end
        end
        return {found, w};
    endfunction

    assign pick_res = pick(eligible);
`endif

    assign eligible  = slot_req & ~inflight_reg;
    assign win_found = pick_res[IW];
    assign win_idx   = pick_res[IW-1:0];
    assign issue_vec = win_found ? (SLOTS'(1) << win_idx) : '0;
    assign cnt_next  = (cnt_reg == CW'(READY_DLY)) ? cnt_reg : cnt_reg + 1'b1;

    // we_next is the value slot_we takes at the coming cen.
    jtgng_rom_dly #(
        .W     (SLOTS),
        .DEPTH (LATENCY)
    ) u_dly (
        .clk  (clk),
        .clr  (clr),
        .cen  (cen),
        .din  (issue_vec),
        .dout (we_next)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            sdram_addr   <= '0;
            sdram_re     <= 1'b0;
            slot_we      <= '0;
            grant_idx    <= '0;
            ready        <= 1'b0;
            inflight_reg <= '0;
            cnt_reg      <= '0;
        end else if (cen) begin
            sdram_re     <= ~sdram_re;
            slot_we      <= we_next;
            inflight_reg <= (inflight_reg & ~we_next) | issue_vec;
            cnt_reg      <= cnt_next;
            ready        <= (cnt_next == CW'(READY_DLY));
            if (win_found) begin
                sdram_addr <= abs_addr[win_idx];
                grant_idx  <= 4'(win_idx);
            end
        end
    end

`ifdef JTGNG_ROM_RR_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr_reg <= IW'(FIXED_PRI);
        end else if (cen && win_found && (int'(win_idx) >= FIXED_PRI)) begin
            rr_ptr_reg <= (int'(win_idx) == SLOTS - 1) ? IW'(FIXED_PRI) : win_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Scoreboard bench for jtgng_rom_arb: directed stimulus pushes expected slot_we
// returns; a monitor pops them and checks the address/index issued LATENCY cens earlier.
module tb_jtgng_rom_arb;

    localparam int SLOTS = 8;
    localparam int AW    = 22;
    localparam int LAT   = 2;
    localparam logic [SLOTS*AW-1:0] OFFS =
        ((176'h1C000) << (3*AW)) | ((176'h3FFFF0) << (2*AW));

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen = 1'b0;
    logic               downloading = 1'b0;
    logic               loop_rst = 1'b0;
    logic [SLOTS-1:0]   slot_req = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_re;
    logic [SLOTS-1:0]   slot_we;
    logic [3:0]         grant_idx;
    logic               ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  we;
        logic [3:0]  idx;
        logic [21:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [3:0]  h_idx  [LAT];
    logic [21:0] h_addr [LAT];

    jtgng_rom_arb #(
        .SLOTS     (SLOTS),
        .AW        (AW),
        .OFFSETS   (OFFS),
        .LATENCY   (LAT),
        .READY_DLY (4),
        .FIXED_PRI (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .sdram_addr  (sdram_addr),
        .sdram_re    (sdram_re),
        .slot_we     (slot_we),
        .grant_idx   (grant_idx),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every slot_we return is matched against the next expected entry.
    always @(posedge clk) begin
        if (cen && !(rst || downloading || loop_rst)) begin
            #1;
            if (slot_we != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected slot_we", 32'(slot_we), 32'h0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("slot_we", 32'(slot_we), 32'(mon_e.we));
                    check("grant_idx at issue", 32'(h_idx[LAT-1]), 32'(mon_e.idx));
                    check("sdram_addr at issue", 32'(h_addr[LAT-1]), 32'(mon_e.addr));
                end
            end
            for (int i = LAT - 1; i > 0; i--) begin
                h_idx[i]  = h_idx[i-1];
                h_addr[i] = h_addr[i-1];
            end
            h_idx[0]  = grant_idx;
            h_addr[0] = sdram_addr;
        end
    end

    task automatic do_cen();
        @(negedge clk) cen = 1'b1;
        @(negedge clk) cen = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst sdram_addr", 32'(sdram_addr), 32'h0);
        check("rst sdram_re", 32'(sdram_re), 32'h0);
        check("rst slot_we", 32'(slot_we), 32'h0);
        check("rst grant_idx", 32'(grant_idx), 32'h0);
        check("rst ready", 32'(ready), 32'h0);
        rst = 1'b0;
    endtask

    task automatic set_addr(input int k, input logic [21:0] a);
        slot_addr[k*AW +: AW] = a;
    endtask

    task automatic push(input int k, input logic [21:0] a);
        exp_t e;
        e.we   = 8'(1 << k);
        e.idx  = 4'(k);
        e.addr = a;
        sb_q.push_back(e);
    endtask

    // Absolute addresses for the test-4 slot map (slot k at relative k*0x10).
    function automatic logic [21:0] t4_addr(input int k);
        case (k)
            2:       return 22'h000010;
            3:       return 22'h01C030;
            default: return 22'(k * 16);
        endcase
    endfunction

    int t4_seq [8];

    initial begin
        // 1: strobe toggling, ready timing, clear sources
        reset_dut();
        check("re before first cen", 32'(sdram_re), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            do_cen();
            check($sformatf("re after cen %0d", k), 32'(sdram_re), 32'(k & 1));
            check($sformatf("ready after cen %0d", k), 32'(ready), (k >= 4) ? 32'h1 : 32'h0);
            check($sformatf("idle slot_we cen %0d", k), 32'(slot_we), 32'h0);
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("ready after rst pulse", 32'(ready), 32'h0);
        check("re after rst pulse", 32'(sdram_re), 32'h0);
        rst = 1'b0;
        repeat (4) do_cen();
        check("ready regained", 32'(ready), 32'h1);
        @(negedge clk) loop_rst = 1'b1;
        @(negedge clk);
        check("ready after loop_rst", 32'(ready), 32'h0);
        loop_rst = 1'b0;

        // 2: single request through a non-zero offset
        reset_dut();
        set_addr(3, 22'h0010);
        push(3, 22'h1C010);
        slot_req = 8'h08;
        do_cen();
        check("t2 sdram_addr", 32'(sdram_addr), 32'h1C010);
        check("t2 grant_idx", 32'(grant_idx), 32'h3);
        slot_req = 8'h00;
        do_cen();
        check("t2 slot_we early", 32'(slot_we), 32'h0);
        do_cen();
        check("t2 slot_we on time", 32'(slot_we), 32'h08);
        do_cen();
        check("t2 slot_we one cen", 32'(slot_we), 32'h0);

        // 3: slot 0 and slot 7 held; slot 0 wins whenever free
        reset_dut();
        set_addr(0, 22'h100);
        set_addr(7, 22'h700);
        for (int i = 0; i < 3; i++) begin
            push(0, 22'h100);
            push(7, 22'h700);
        end
        slot_req = 8'h81;
        repeat (8) do_cen();
        slot_req = 8'h00;
        repeat (3) do_cen();

        // 4 and 5: slots 1..7 held; slot 2 address wraps past 2^22
        reset_dut();
        for (int k = 1; k < 8; k++) set_addr(k, 22'(k * 16));
`ifdef JTGNG_ROM_RR_EN
        t4_seq = '{1, 2, 3, 4, 5, 6, 7, 1};
`else
        t4_seq = '{1, 2, 3, 1, 2, 3, 1, 2};
`endif
        foreach (t4_seq[i]) push(t4_seq[i], t4_addr(t4_seq[i]));
        slot_req = 8'hFE;
        for (int k = 1; k <= 8; k++) begin
            do_cen();
            if (k == 2) check("t5 wrapped addr", 32'(sdram_addr), 32'h000010);
        end
        slot_req = 8'h00;
        repeat (3) do_cen();

        // 6: downloading drops two inflight reads; pending requests reissue
        reset_dut();
        set_addr(0, 22'h100);
        set_addr(1, 22'h010);
        slot_req = 8'h03;
        repeat (2) do_cen();
        @(negedge clk) downloading = 1'b1;
        @(negedge clk);
        check("dl sdram_addr", 32'(sdram_addr), 32'h0);
        check("dl sdram_re", 32'(sdram_re), 32'h0);
        check("dl slot_we", 32'(slot_we), 32'h0);
        check("dl grant_idx", 32'(grant_idx), 32'h0);
        check("dl ready", 32'(ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            do_cen();
            check("dl slot_we held", 32'(slot_we), 32'h0);
        end
        @(negedge clk) downloading = 1'b0;
        push(0, 22'h100);
        push(1, 22'h010);
        repeat (2) do_cen();
        slot_req = 8'h00;
        repeat (3) do_cen();

        repeat (4) do_cen();
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
